// File: rtl/pc_if.sv
// Controller <-> program counter command/status bundle.
// STACK_DEPTH sizes the return-stack occupancy field.
interface pc_if #(
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic            pc_inc;
  logic            pc_load;
  logic            pc_call;
  logic            pc_ret;
  logic            err_clr;
  logic [15:0]     bus;
  logic [15:0]     mem_in;
  logic [15:0]     pc_out;
  logic [SP_W-1:0] sp;
  logic            stack_full;
  logic            stack_empty;
  logic            err_ovf;
  logic            err_unf;

  modport master (
    output pc_inc, pc_load, pc_call, pc_ret, err_clr, bus, mem_in,
    input  pc_out, sp, stack_full, stack_empty, err_ovf, err_unf
  );

  modport slave (
    input  pc_inc, pc_load, pc_call, pc_ret, err_clr, bus, mem_in,
    output pc_out, sp, stack_full, stack_empty, err_ovf, err_unf
  );
endinterface

// File: rtl/pc_unit.sv
// SAP-2 program counter: increment, jump, CALL/RET. Define PC_STACK_EN for an internal
// return LIFO; otherwise RET loads the return address from the memory block's MDR.
module pc_unit #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  pif
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] pc, pc_nxt;

  assign pif.pc_out = 16'(pc);

`ifdef PC_STACK_EN
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_nxt, sp_m1;
  logic              full, empty, push, ovf_set, unf_set, ovf_q, unf_q;
  logic              unused_ok;

  assign full      = (sp == SP_W'(STACK_DEPTH));
  assign empty     = (sp == '0);
  assign sp_m1     = sp - 1'b1;
  assign unused_ok = ^pif.mem_in;

  // ret > call > load > inc; only the winning command takes effect
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (pif.pc_ret) begin
      if (empty) unf_set = 1'b1;
      else begin
        pc_nxt = stack[sp_m1[SP_W-2:0]];
        sp_nxt = sp_m1;
      end
    end else if (pif.pc_call) begin
      pc_nxt = pif.bus[ADDR_W-1:0];
      if (full) ovf_set = 1'b1;
      else begin
        push   = 1'b1;
        sp_nxt = sp + 1'b1;
      end
    end else if (pif.pc_load) begin
      pc_nxt = pif.bus[ADDR_W-1:0];
    end else if (pif.pc_inc) begin
      pc_nxt = pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= ADDR_W'(RESET_PC);
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      sp    <= sp_nxt;
      ovf_q <= ovf_set | (ovf_q & ~pif.err_clr);
      unf_q <= unf_set | (unf_q & ~pif.err_clr);
    end
  end

  // Storage is deliberately left uninitialised on reset; sp alone tracks validity.
  always_ff @(posedge clk) begin
    if (push && rst) stack[sp[SP_W-2:0]] <= pc;
  end

  assign pif.sp          = sp;
  assign pif.stack_full  = full;
  assign pif.stack_empty = empty;
  assign pif.err_ovf     = ovf_q;
  assign pif.err_unf     = unf_q;
`else
  logic unused_ok;

  assign unused_ok = pif.err_clr;

  // Without a stack, CALL is a plain jump and RET takes the address from MDR.
  always_comb begin
    pc_nxt = pc;
    if (pif.pc_ret)                      pc_nxt = pif.mem_in[ADDR_W-1:0];
    else if (pif.pc_call || pif.pc_load) pc_nxt = pif.bus[ADDR_W-1:0];
    else if (pif.pc_inc)                 pc_nxt = pc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= ADDR_W'(RESET_PC);
    else      pc <= pc_nxt;
  end

  assign pif.sp          = '0;
  assign pif.stack_full  = 1'b0;
  assign pif.stack_empty = 1'b1;
  assign pif.err_ovf     = 1'b0;
  assign pif.err_unf     = 1'b0;
`endif
endmodule
